// File: rtl/ip_uart_rx_inst_if.sv
// I/O bus bundle shared by the UART TX and RX blocks: address/command from the CPU side,
// ready and registered read data from the peripheral side.
interface ip_uart_rx_inst_if;
    logic [7:0] bus_address;
    logic       bus_ioreq;
    logic       bus_write;
    logic       bus_valid;
    logic       bus_ready;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_rdata_en;

    modport master (
        output bus_address, bus_ioreq, bus_write, bus_valid, bus_wdata,
        input  bus_ready, bus_rdata, bus_rdata_en
    );

    modport slave (
        input  bus_address, bus_ioreq, bus_write, bus_valid, bus_wdata,
        output bus_ready, bus_rdata, bus_rdata_en
    );
endinterface

// File: rtl/ip_uart_rx_inst.sv
// 8N1 UART receiver with an 8-entry receive FIFO, read through a data port (pops) and a
// status port (clears error flags) on the shared I/O bus.
module ip_uart_rx_inst #(
    parameter int clk_freq  = 27000000,
    parameter int uart_freq = 115200
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ip_uart_rx_inst_if.slave     bus,
    input  logic                 uart_rx
);

    localparam int          c_div       = clk_freq / uart_freq;
    localparam int          c_half      = c_div / 2;
    localparam logic [15:0] c_div_m1    = 16'(c_div - 1);
    localparam logic [15:0] c_half_m1   = 16'(c_half - 1);
    localparam logic [7:0]  c_data_port = 8'h11;
    localparam logic [7:0]  c_stat_port = 8'h12;

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_start = 2'd1,
        st_data  = 2'd2,
        st_stop  = 2'd3
    } state_t;

    logic        sync1_r, sync2_r, sync3_r;
    logic        start_s;
    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [2:0]  idx_r, idx_s;
    logic [7:0]  shreg_r, shreg_s;
    logic        push_s, frame_err_s;

    logic [7:0]  mem_r [0:7];
    logic [2:0]  wr_ptr_r, rd_ptr_r;
    logic [3:0]  count_r;
    logic        overrun_r, frame_r;
    logic        empty_s, full_s, pop_s, push_ok_s, overrun_set_s;
    logic        w_dec_s, rd_acc_s, rd_data_s, rd_stat_s;
    logic [7:0]  status_s;
    logic [7:0]  rdata_r;
    logic        rdata_en_r;
    logic        unused_s;

    assign unused_s = ^bus.bus_wdata;

    // Two-stage synchronizer plus edge register on the serial input
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            sync3_r <= 1'b1;
        end else begin
            sync1_r <= uart_rx;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign start_s = sync3_r & ~sync2_r;

    // Receiver state, bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= st_idle;
            cnt_r   <= 16'd0;
            idx_r   <= 3'd0;
            shreg_r <= 8'h00;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shreg_r <= shreg_s;
        end
    end

    // Next-state logic; a sample is taken whenever the bit timer reaches zero
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        shreg_s     = shreg_r;
        push_s      = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            st_idle: begin
                if (start_s) begin
                    cnt_s   = c_half_m1;
                    state_s = st_start;
                end else begin
                    state_s = st_idle;
                end
            end
            st_start: begin
                if (cnt_r == 16'd0) begin
                    if (!sync2_r) begin
                        cnt_s   = c_div_m1;
                        idx_s   = 3'd0;
                        state_s = st_data;
                    end else begin
                        state_s = st_idle;
                    end
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
            st_data: begin
                if (cnt_r == 16'd0) begin
                    shreg_s = {sync2_r, shreg_r[7:1]};
                    cnt_s   = c_div_m1;
                    idx_s   = idx_r + 3'd1;
                    if (idx_r == 3'd7) begin
                        state_s = st_stop;
                    end else begin
                        state_s = st_data;
                    end
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
            st_stop: begin
                if (cnt_r == 16'd0) begin
                    if (sync2_r) begin
                        push_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                    state_s = st_idle;
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
            default: begin
                state_s = st_idle;
            end
        endcase
    end

    assign w_dec_s   = bus.bus_ioreq &&
                       ((bus.bus_address == c_data_port) || (bus.bus_address == c_stat_port));
    assign rd_acc_s  = w_dec_s && bus.bus_valid && !bus.bus_write;
    assign rd_data_s = rd_acc_s && (bus.bus_address == c_data_port);
    assign rd_stat_s = rd_acc_s && (bus.bus_address == c_stat_port);

    assign empty_s       = (count_r == 4'd0);
    assign full_s        = (count_r == 4'd8);
    assign pop_s         = rd_data_s && !empty_s;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still fits
    assign push_ok_s     = push_s && (!full_s || pop_s);
    assign overrun_set_s = push_s && full_s && !pop_s;
    assign status_s      = {count_r, frame_r, overrun_r, full_s, !empty_s};

    // FIFO storage; not reset, contents are qualified by count
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= shreg_r;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= 3'd0;
            rd_ptr_r <= 3'd0;
            count_r  <= 4'd0;
        end else begin
            wr_ptr_r <= push_ok_s ? wr_ptr_r + 3'd1 : wr_ptr_r;
            rd_ptr_r <= pop_s ? rd_ptr_r + 3'd1 : rd_ptr_r;
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags: a new error in the same cycle as a status read wins
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overrun_r <= 1'b0;
            frame_r   <= 1'b0;
        end else begin
            overrun_r <= overrun_set_s ? 1'b1 : (rd_stat_s ? 1'b0 : overrun_r);
            frame_r   <= frame_err_s   ? 1'b1 : (rd_stat_s ? 1'b0 : frame_r);
        end
    end

    // Registered read data, valid the cycle after the read is accepted
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_r    <= 8'h00;
            rdata_en_r <= 1'b0;
        end else if (rd_data_s) begin
            rdata_r    <= empty_s ? 8'h00 : mem_r[rd_ptr_r];
            rdata_en_r <= 1'b1;
        end else if (rd_stat_s) begin
            rdata_r    <= status_s;
            rdata_en_r <= 1'b1;
        end else begin
            rdata_r    <= 8'h00;
            rdata_en_r <= 1'b0;
        end
    end

    assign bus.bus_ready    = w_dec_s;
    assign bus.bus_rdata    = rdata_r;
    assign bus.bus_rdata_en = rdata_en_r;

endmodule

// File: tb/tb_ip_uart_rx_inst.sv
// Directed bench for ip_uart_rx_inst at c_div = 10: frames are driven bit by bit and
// results are read back through the bus against hand-computed values.
module tb_ip_uart_rx_inst;

    logic clk = 1'b0;
    logic reset_n;
    logic uart_rx;
    int   total = 0;
    int   bad   = 0;

    ip_uart_rx_inst_if bus_if ();

    ip_uart_rx_inst #(
        .clk_freq  (1000000),
        .uart_freq (100000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic en);
        bus_if.bus_address = a;
        bus_if.bus_ioreq   = 1'b1;
        bus_if.bus_write   = 1'b0;
        bus_if.bus_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus_if.bus_valid   = 1'b0;
        bus_if.bus_ioreq   = 1'b0;
        d  = bus_if.bus_rdata;
        en = bus_if.bus_rdata_en;
    endtask

    // One 8N1 frame, 10 clk per bit; optional data read or reset pulse at a given cycle
    task automatic frame(input logic [7:0] d, input logic stop, input int rd_cycle,
                         input int rst_cycle, output logic [7:0] rd_val);
        logic [9:0] bits;
        bits   = {stop, d, 1'b0};
        rd_val = 8'h00;
        for (int c = 0; c < 100; c++) begin
            uart_rx = bits[c / 10];
            if (c == rd_cycle) begin
                bus_if.bus_address = 8'h11;
                bus_if.bus_ioreq   = 1'b1;
                bus_if.bus_write   = 1'b0;
                bus_if.bus_valid   = 1'b1;
            end else begin
                bus_if.bus_valid   = 1'b0;
                bus_if.bus_ioreq   = 1'b0;
            end
            if (c == rst_cycle) reset_n = 1'b0;
            else if (c == rst_cycle + 2) reset_n = 1'b1;
            @(posedge clk);
            #1;
            if (c == rd_cycle) rd_val = bus_if.bus_rdata;
        end
        uart_rx          = 1'b1;
        bus_if.bus_valid = 1'b0;
        bus_if.bus_ioreq = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       en;
        logic [7:0] v;

        reset_n            = 1'b0;
        uart_rx            = 1'b1;
        bus_if.bus_address = 8'h00;
        bus_if.bus_ioreq   = 1'b0;
        bus_if.bus_write   = 1'b0;
        bus_if.bus_valid   = 1'b0;
        bus_if.bus_wdata   = 8'h00;
        idle(3);
        reset_n = 1'b1;
        check("reset_rdata", bus_if.bus_rdata, 8'h00);
        check("reset_rdata_en", {7'd0, bus_if.bus_rdata_en}, 8'h00);
        check("reset_ready", {7'd0, bus_if.bus_ready}, 8'h00);

        // Single good frame
        frame(8'hA5, 1'b1, -1, -1, v);
        idle(2);
        bus_read(8'h12, d, en);
        check("a5_status", d, 8'h11);
        check("a5_status_en", {7'd0, en}, 8'h01);
        bus_read(8'h11, d, en);
        check("a5_data", d, 8'hA5);
        check("a5_data_en", {7'd0, en}, 8'h01);
        idle(1);
        check("a5_en_one_cycle", {7'd0, bus_if.bus_rdata_en}, 8'h00);
        bus_read(8'h12, d, en);
        check("a5_status_after", d, 8'h00);

        // Short low glitch must not start a frame
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(20);
        bus_read(8'h12, d, en);
        check("glitch_status", d, 8'h00);

        // Framing error
        frame(8'h3C, 1'b0, -1, -1, v);
        idle(3);
        bus_read(8'h12, d, en);
        check("frame_status", d, 8'h08);
        bus_read(8'h12, d, en);
        check("frame_status_clr", d, 8'h00);

        // Writes are accepted without effect; other addresses are not decoded
        bus_if.bus_address = 8'h11;
        bus_if.bus_ioreq   = 1'b1;
        bus_if.bus_write   = 1'b1;
        bus_if.bus_valid   = 1'b1;
        bus_if.bus_wdata   = 8'h5F;
        #1;
        check("write_ready", {7'd0, bus_if.bus_ready}, 8'h01);
        idle(1);
        check("write_no_rdata_en", {7'd0, bus_if.bus_rdata_en}, 8'h00);
        bus_if.bus_address = 8'h13;
        bus_if.bus_write   = 1'b0;
        #1;
        check("nodecode_ready", {7'd0, bus_if.bus_ready}, 8'h00);
        idle(1);
        check("nodecode_rdata_en", {7'd0, bus_if.bus_rdata_en}, 8'h00);
        bus_if.bus_valid = 1'b0;
        bus_if.bus_ioreq = 1'b0;
        bus_read(8'h12, d, en);
        check("write_status", d, 8'h00);

        // Nine frames with no reads: eight stored, ninth overruns
        for (int i = 0; i < 9; i++) frame(8'(i), 1'b1, -1, -1, v);
        idle(3);
        bus_read(8'h12, d, en);
        check("ovr_status", d, 8'h87);
        for (int i = 0; i < 8; i++) begin
            bus_read(8'h11, d, en);
            check($sformatf("ovr_data%0d", i), d, 8'(i));
        end
        bus_read(8'h11, d, en);
        check("empty_data", d, 8'h00);
        check("empty_data_en", {7'd0, en}, 8'h01);
        bus_read(8'h12, d, en);
        check("ovr_status_clr", d, 8'h00);

        // Push and pop in the same cycle on a full FIFO
        for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1'b1, -1, -1, v);
        idle(2);
        bus_read(8'h12, d, en);
        check("full_status", d, 8'h83);
        frame(8'h18, 1'b1, 97, -1, v);
        check("same_cycle_pop", v, 8'h10);
        idle(2);
        bus_read(8'h12, d, en);
        check("same_cycle_status", d, 8'h83);
        for (int i = 0; i < 8; i++) begin
            bus_read(8'h11, d, en);
            check($sformatf("drain%0d", i), d, 8'h11 + 8'(i));
        end
        bus_read(8'h12, d, en);
        check("drain_status", d, 8'h00);

        // Reset in the middle of a frame empties the FIFO and drops the frame
        frame(8'h33, 1'b1, -1, -1, v);
        frame(8'hF0, 1'b1, -1, 55, v);
        idle(3);
        bus_read(8'h12, d, en);
        check("midreset_status", d, 8'h00);
        frame(8'h5A, 1'b1, -1, -1, v);
        idle(2);
        bus_read(8'h12, d, en);
        check("post_reset_status", d, 8'h11);
        bus_read(8'h11, d, en);
        check("post_reset_data", d, 8'h5A);
        bus_read(8'h12, d, en);
        check("post_reset_final", d, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
